// File: rtl/pipe_stage_skid_pkg.sv
// ============================================================================
// Module  : pipe_pkg
// Brief   : Shared encodings, per-stage default widths and control bit map
//           for pipe_stage_skid.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  // State encoding doubles as the occupancy count
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int IF_ID_CTRL_W  = 8;
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_CTRL_W  = 16;
  localparam int ID_EX_DATA_W  = 192;
  localparam int EX_MEM_CTRL_W = 12;
  localparam int EX_MEM_DATA_W = 128;
  localparam int MEM_WB_CTRL_W = 8;
  localparam int MEM_WB_DATA_W = 72;

  // Control field layout shared with the decoder
  localparam int CTRL_BIT_REGWRITE = 0;
  localparam int CTRL_BIT_MEMWRITE = 1;
  localparam int CTRL_BIT_MEMREAD  = 2;
  localparam int CTRL_BIT_ISFPU    = 3;
  localparam int CTRL_OP_LSB       = 4;
  localparam int CTRL_OP_W         = 6;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_skid_if.sv
// ============================================================================
// Module  : pipe_stage_skid_if
// Brief   : valid/ready handshake bundle carrying control and data payloads.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_stage_skid_if #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 192
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input  ready);
  modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

`default_nettype wire

// File: rtl/pipe_stage_skid_perf_ctr.sv
// ============================================================================
// Module  : pipe_perf_ctr
// Brief   : 32-bit saturating event counter, used when PIPE_STAGE_SKID_PERF_EN
//           is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_perf_ctr (
  input  wire         clk,
  input  wire         rst,
  input  wire         i_inc,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= 32'd0;
    end else if (i_inc && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
// Module  : pipe_stage_skid
// Brief   : Pipeline stage register with valid/ready handshake and a 2-entry
//           skid buffer. PIPE_STAGE_SKID_PERF_EN adds stall/bubble counters.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int          CTRL_W   = ID_EX_CTRL_W,
  parameter int          DATA_W   = ID_EX_DATA_W,
  parameter int unsigned CLR_DATA = 1
) (
  input  wire               clk,
  input  wire               rst,
  input  wire               i_flush,
  pipe_stage_skid_if.slave  s_up,
  pipe_stage_skid_if.master m_dn,
  output logic [1:0]        o_occupancy
`ifdef PIPE_STAGE_SKID_PERF_EN
  ,
  output logic [31:0]       o_perf_stall_cnt,
  output logic [31:0]       o_perf_bubble_cnt
`endif
);

  localparam logic c_clr = (CLR_DATA != 0);

  state_t            r_state;
  logic              r_out_valid;
  logic              r_skid_valid;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  logic w_in_ready;
  logic w_acc;
  logic w_drn;

  // Backpressure comes from registered state only, never from downstream ready
  assign w_in_ready = rst & ~r_skid_valid;
  assign w_acc      = s_up.valid & w_in_ready;
  assign w_drn      = r_out_valid & m_dn.ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_EMPTY;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_main_data  <= '0;
      r_skid_ctrl  <= '0;
      r_skid_data  <= '0;
    end else if (i_flush) begin
      r_state      <= ST_EMPTY;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_skid_ctrl  <= '0;
      if (c_clr) begin
        r_main_data <= '0;
        r_skid_data <= '0;
      end
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
            r_main_ctrl <= s_up.ctrl;
            r_main_data <= s_up.data;
          end
        end
        ST_ONE: begin
          if (w_acc && w_drn) begin
            r_main_ctrl <= s_up.ctrl;
            r_main_data <= s_up.data;
          end else if (w_acc) begin
            r_state      <= ST_FULL;
            r_skid_valid <= 1'b1;
            r_skid_ctrl  <= s_up.ctrl;
            r_skid_data  <= s_up.data;
          end else if (w_drn) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_main_ctrl <= '0;
            if (c_clr) begin
              r_main_data <= '0;
            end
          end
        end
        ST_FULL: begin
          // Skid always refills main so entry order is preserved
          if (w_drn) begin
            r_state      <= ST_ONE;
            r_skid_valid <= 1'b0;
            r_main_ctrl  <= r_skid_ctrl;
            r_main_data  <= r_skid_data;
            r_skid_ctrl  <= '0;
            if (c_clr) begin
              r_skid_data <= '0;
            end
          end
        end
        default: begin
          r_state      <= ST_EMPTY;
          r_out_valid  <= 1'b0;
          r_skid_valid <= 1'b0;
          r_main_ctrl  <= '0;
          r_skid_ctrl  <= '0;
        end
      endcase
    end
  end

  assign s_up.ready  = w_in_ready;
  assign m_dn.valid  = r_out_valid;
  assign m_dn.ctrl   = r_main_ctrl;
  assign m_dn.data   = r_main_data;
  assign o_occupancy = r_state;

`ifdef PIPE_STAGE_SKID_PERF_EN
  pipe_perf_ctr u_stall_ctr (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (r_out_valid & ~m_dn.ready),
    .o_count (o_perf_stall_cnt)
  );

  pipe_perf_ctr u_bubble_ctr (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (~r_out_valid & m_dn.ready),
    .o_count (o_perf_bubble_cnt)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ============================================================================
// Module  : tb_pipe_stage_skid
// Brief   : Directed table, hand sequences and random traffic against a queue
//           model; two instances cover CLR_DATA = 1 and CLR_DATA = 0.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid;

  localparam int CW = 16;
  localparam int DW = 192;

  typedef struct {
    logic          rst, fl, iv;
    logic [CW-1:0] ic;
    logic          ordy;
    logic          ev;
    logic [CW-1:0] ec;
    logic [1:0]    eo;
    logic          eir;
  } vec_t;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk;
  logic          t_rst, t_fl, t_iv, t_ordy;
  logic [CW-1:0] t_ic;
  logic [DW-1:0] t_id;
  logic [1:0]    occ1, occ0;

  int n_vec  = 0;
  int n_fail = 0;

  ent_t          mq[$];
  logic [DW-1:0] hold0;
  vec_t          tbl[$];

  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) up1 ();
  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) dn1 ();
  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) up0 ();
  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) dn0 ();

  assign up1.valid = t_iv;
  assign up1.ctrl  = t_ic;
  assign up1.data  = t_id;
  assign dn1.ready = t_ordy;
  assign up0.valid = t_iv;
  assign up0.ctrl  = t_ic;
  assign up0.data  = t_id;
  assign dn0.ready = t_ordy;

`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [31:0] stall1, bubble1, stall0, bubble0;
`endif

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1)) dut1 (
    .clk         (clk),
    .rst         (t_rst),
    .i_flush     (t_fl),
    .s_up        (up1),
    .m_dn        (dn1),
    .o_occupancy (occ1)
`ifdef PIPE_STAGE_SKID_PERF_EN
    ,
    .o_perf_stall_cnt  (stall1),
    .o_perf_bubble_cnt (bubble1)
`endif
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(0)) dut0 (
    .clk         (clk),
    .rst         (t_rst),
    .i_flush     (t_fl),
    .s_up        (up0),
    .m_dn        (dn0),
    .o_occupancy (occ0)
`ifdef PIPE_STAGE_SKID_PERF_EN
    ,
    .o_perf_stall_cnt  (stall0),
    .o_perf_bubble_cnt (bubble0)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] dat(input logic [CW-1:0] c);
    return {12{c}};
  endfunction

  function automatic vec_t mk(input logic r, input logic f, input logic iv,
                              input logic [CW-1:0] ic, input logic ordy,
                              input logic ev, input logic [CW-1:0] ec,
                              input logic [1:0] eo, input logic eir);
    vec_t v;
    v.rst = r; v.fl = f; v.iv = iv; v.ic = ic; v.ordy = ordy;
    v.ev = ev; v.ec = ec; v.eo = eo; v.eir = eir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: ordered queue of at most two entries
  task automatic model_update();
    bit drn;
    bit acc;
    if (!t_rst) begin
      mq.delete();
      hold0 = '0;
    end else if (t_fl) begin
      mq.delete();
    end else begin
      drn = (mq.size() > 0) && t_ordy;
      acc = t_iv && (mq.size() < 2);
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back('{c: t_ic, d: t_id});
    end
    if (mq.size() > 0) hold0 = mq[0].d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [CW-1:0] ic, input logic [DW-1:0] id, input logic ordy);
    t_rst = r; t_fl = f; t_iv = iv; t_ic = ic; t_id = id; t_ordy = ordy;
    tick();
  endtask

  task automatic check_model();
    logic          ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed1, ed0;
    ev  = (mq.size() > 0);
    ec  = ev ? mq[0].c : '0;
    ed1 = ev ? mq[0].d : '0;
    ed0 = ev ? mq[0].d : hold0;
    chk("rnd_valid",  DW'(dn1.valid), DW'(ev));
    chk("rnd_ctrl",   DW'(dn1.ctrl),  DW'(ec));
    chk("rnd_data1",  dn1.data,       ed1);
    chk("rnd_occ",    DW'(occ1),      DW'(mq.size()));
    chk("rnd_ready",  DW'(up1.ready), DW'(t_rst && (mq.size() < 2)));
    chk("rnd_ctrl0",  DW'(dn0.ctrl),  DW'(ec));
    chk("rnd_data0",  dn0.data,       ed0);
  endtask

  initial begin
    // Reset held with junk on the input
    tbl.push_back(mk(0, 0, 1, 16'hFFFF, 0,  0, 16'h0, 2'd0, 0));
    tbl.push_back(mk(0, 0, 1, 16'hFFFF, 0,  0, 16'h0, 2'd0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1,  0, 16'h0, 2'd0, 1));
    // Streaming 1..8
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(1, 0, 1, CW'(k), 1,  1, CW'(k), 2'd1, 1));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1,  0, 16'h0, 2'd0, 1));
    // Backpressure A, B, C
    tbl.push_back(mk(1, 0, 1, 16'h0011, 1,  1, 16'h11, 2'd1, 1));
    tbl.push_back(mk(1, 0, 1, 16'h0022, 0,  1, 16'h11, 2'd2, 0));
    tbl.push_back(mk(1, 0, 1, 16'h0033, 0,  1, 16'h11, 2'd2, 0));
    tbl.push_back(mk(1, 0, 1, 16'h0033, 1,  1, 16'h22, 2'd1, 1));
    tbl.push_back(mk(1, 0, 1, 16'h0033, 1,  1, 16'h33, 2'd1, 1));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1,  0, 16'h0, 2'd0, 1));
    // Flush while FULL with 0x44 offered
    tbl.push_back(mk(1, 0, 1, 16'h0055, 0,  1, 16'h55, 2'd1, 1));
    tbl.push_back(mk(1, 0, 1, 16'h0066, 0,  1, 16'h55, 2'd2, 0));
    tbl.push_back(mk(1, 1, 1, 16'h0044, 0,  0, 16'h0, 2'd0, 1));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1,  0, 16'h0, 2'd0, 1));
    // Flush while ONE with 0x44 acceptable: dropped
    tbl.push_back(mk(1, 0, 1, 16'h0077, 0,  1, 16'h77, 2'd1, 1));
    tbl.push_back(mk(1, 1, 1, 16'h0044, 0,  0, 16'h0, 2'd0, 1));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1,  0, 16'h0, 2'd0, 1));
    // Reset mid-operation while FULL
    tbl.push_back(mk(1, 0, 1, 16'h0099, 0,  1, 16'h99, 2'd1, 1));
    tbl.push_back(mk(1, 0, 1, 16'h00AA, 0,  1, 16'h99, 2'd2, 0));
    tbl.push_back(mk(0, 0, 1, 16'h00BB, 0,  0, 16'h0, 2'd0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0,  0, 16'h0, 2'd0, 1));

    t_rst = 1'b0; t_fl = 1'b0; t_iv = 1'b0; t_ordy = 1'b0; t_ic = '0; t_id = '0;
    hold0 = '0;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].ic, dat(tbl[i].ic), tbl[i].ordy);
      chk($sformatf("tbl%0d_valid", i), DW'(dn1.valid), DW'(tbl[i].ev));
      chk($sformatf("tbl%0d_ctrl", i),  DW'(dn1.ctrl),  DW'(tbl[i].ec));
      chk($sformatf("tbl%0d_occ", i),   DW'(occ1),      DW'(tbl[i].eo));
      chk($sformatf("tbl%0d_ready", i), DW'(up1.ready), DW'(tbl[i].eir));
      chk($sformatf("tbl%0d_data", i),  dn1.data,       tbl[i].ev ? dat(tbl[i].ec) : '0);
      chk($sformatf("tbl%0d_ctrl0", i), DW'(dn0.ctrl),  DW'(tbl[i].ec));
    end

    // Data retention on flush depends on CLR_DATA
    drive(1, 0, 1, 16'h0101, {12{16'hDEAD}}, 0);
    chk("hold_data0_loaded", dn0.data, {12{16'hDEAD}});
    drive(1, 1, 0, 16'h0000, '0, 0);
    chk("flush_ctrl0",  DW'(dn0.ctrl), '0);
    chk("flush_data0",  dn0.data,      {12{16'hDEAD}});
    chk("flush_ctrl1",  DW'(dn1.ctrl), '0);
    chk("flush_data1",  dn1.data,      '0);

    // Random traffic against the queue model
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 9) < 7), CW'($urandom),
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            ($urandom_range(0, 9) < 6));
      check_model();
    end

`ifdef PIPE_STAGE_SKID_PERF_EN
    drive(0, 0, 0, 16'h0, '0, 0);
    drive(1, 0, 1, 16'h0005, dat(16'h0005), 0);
    for (int k = 0; k < 5; k++) drive(1, 0, 0, 16'h0, '0, 0);
    drive(1, 0, 0, 16'h0, '0, 1);
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 16'h0, '0, 1);
    chk("perf_stall",  DW'(stall1),  DW'(32'd5));
    chk("perf_bubble", DW'(bubble1), DW'(32'd3));
    chk("perf_stall0", DW'(stall0),  DW'(32'd5));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
